// File: rtl/lsu_multibeat.sv
// -----------------------------------------------------------------------------
// lsu_multibeat
//
// Load/store unit for the KCP53K CPU, placed between execute and register
// writeback. It performs byte, half, word and dword loads and stores over a
// classic Wishbone master port of width DW. Accesses wider than the bus are
// split into consecutive beats, lowest bytes first. Narrow accesses use lane
// selects, and loads are sign- or zero-extended to XLEN. A request flagged
// nomem_i does not start a bus cycle. It returns the effective address on
// the writeback port instead.
//
// Parameters
//   XLEN : register/address width
//   DW   : Wishbone data width (8, 16, 32 or 64)
//   SW   : byte lanes, DW/8 (derived)
//
// Ports
//   clk_i, reset_i      clock, asynchronous active-high reset
//   req_i               request strobe, sampled only while idle
//   nomem_i             pass addr_i to writeback with no bus cycle
//   we_i                1 = store, 0 = load
//   size_i              00 byte, 01 half, 10 word, 11 dword
//   signed_i            load extension: 1 = sign, 0 = zero
//   addr_i, dat_i       effective address and store data
//   busy_o              transfer in progress
//   rwe_o, dat_o        one-cycle writeback enable and writeback data
//   misalign_o          one-cycle pulse, misaligned request rejected
//   wbm*_o / wbm*_i     Wishbone master: adr, dat out/in, sel, we, stb, cyc, ack
// -----------------------------------------------------------------------------
module lsu_multibeat #(
  parameter int XLEN = 64,
  parameter int DW   = 16,
  parameter int SW   = DW / 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic            nomem_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] dat_i,
  output logic            busy_o,
  output logic            rwe_o,
  output logic [XLEN-1:0] dat_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] wbmadr_o,
  output logic [DW-1:0]   wbmdat_o,
  input  logic [DW-1:0]   wbmdat_i,
  output logic [SW-1:0]   wbmsel_o,
  output logic            wbmwe_o,
  output logic            wbmstb_o,
  output logic            wbmcyc_o,
  input  logic            wbmack_i
);

  localparam int LOG2SW = $clog2(SW);
  localparam int OFFW   = (SW > 1) ? $clog2(SW) : 1;
  localparam int IW     = $clog2(XLEN);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_beat;      // up to 8 beats (dword over an 8-bit bus)
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_data;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_signed;
  logic [XLEN-1:0]   r_rdata;     // load bytes gathered from earlier beats
  logic              r_rwe;
  logic [XLEN-1:0]   r_dat;
  logic              r_misalign;

  // ---------------------------------------------------------------------------
  // Decoded request / beat information
  // ---------------------------------------------------------------------------
  logic              w_mis_in;    // incoming request is misaligned
  logic [4:0]        w_nbytes;    // 2^size
  logic              w_multi;     // access wider than the bus
  logic [4:0]        w_nbeats;
  logic              w_last;      // current beat is the final one
  logic [OFFW-1:0]   w_off;       // lane offset of a single-beat access
  logic [XLEN-1:0]   w_beat_adr;
  logic [DW-1:0]     w_wdat;
  logic [SW-1:0]     w_sel;
  logic [XLEN-1:0]   w_asm;       // load bytes including the current beat
  logic [XLEN-1:0]   w_ext;       // extended writeback value
  logic              w_sbit;

  logic              w_nomem_hit;
  logic              w_mis_hit;
  logic              w_accept;
  logic              w_beat_ack;
  logic              w_done;

  // A request is misaligned when addr is not a multiple of its own size.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the case can leave it unassigned (no latch).
    w_mis_in = 1'b0;
    case (size_i)
      2'd1:    w_mis_in = addr_i[0];
      2'd2:    w_mis_in = |addr_i[1:0];
      2'd3:    w_mis_in = |addr_i[2:0];
      default: w_mis_in = 1'b0;
    endcase
  end

  assign w_nbytes   = 5'd1 << r_size;
  assign w_multi    = (w_nbytes > 5'(SW));
  assign w_nbeats   = w_multi ? (w_nbytes >> LOG2SW) : 5'd1;
  assign w_last     = ({1'b0, r_beat} == (w_nbeats - 5'd1));
  assign w_off      = r_addr[OFFW-1:0] & OFFW'(SW - 1);
  // The full byte address goes out; the lane offset bits are kept.
  assign w_beat_adr = r_addr + (XLEN'(r_beat) << LOG2SW);

  // Store data and lane selects for the beat on the bus.
  always_comb begin
    w_wdat = '0;
    w_sel  = '0;
    if (w_multi) begin
      w_wdat = r_data[IW'(int'(r_beat) * DW) +: DW];
      w_sel  = '1;
    end else begin
      // The low 2^size bytes are repeated across every lane, so the selected
      // lanes always carry the right bytes whatever the offset.
      for (int i = 0; i < SW; i++) begin
        w_wdat[i*8 +: 8] = r_data[IW'((i & (int'(w_nbytes) - 1)) * 8) +: 8];
        w_sel[i]         = (i >= int'(w_off)) &&
                           (i < int'(w_off) + int'(w_nbytes));
      end
    end
  end

  // Load assembly and extension. A multi-beat load ORs each beat into its
  // slot of r_rdata, which is cleared when the request is accepted. A
  // single-beat load shifts the selected lanes down to bit 0.
  always_comb begin
    w_asm = r_rdata;
    if (w_multi) begin
      w_asm = r_rdata | (XLEN'(wbmdat_i) << (int'(r_beat) * DW));
    end else begin
      w_asm = XLEN'(wbmdat_i >> (int'(w_off) * 8));
    end
  end

  always_comb begin
    w_ext  = '0;
    w_sbit = r_signed & w_asm[IW'(8 * int'(w_nbytes) - 1)];
    for (int i = 0; i < XLEN; i++) begin
      if (i < 8 * int'(w_nbytes)) begin
        w_ext[i] = w_asm[i];
      end else begin
        w_ext[i] = w_sbit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, whatever order the blocks evaluate in.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, event strobes and bus outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_nomem_hit = 1'b0;
    w_mis_hit   = 1'b0;
    w_accept    = 1'b0;
    w_beat_ack  = 1'b0;
    w_done      = 1'b0;
    busy_o      = 1'b0;
    wbmcyc_o    = 1'b0;
    wbmstb_o    = 1'b0;
    wbmwe_o     = 1'b0;
    wbmadr_o    = '0;
    wbmdat_o    = '0;
    wbmsel_o    = '0;

    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (nomem_i) begin
            w_nomem_hit = 1'b1;
          end else if (w_mis_in) begin
            w_mis_hit = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_XFER;
          end
        end
      end

      S_XFER: begin
        busy_o   = 1'b1;
        wbmcyc_o = 1'b1;
        wbmstb_o = 1'b1;
        wbmwe_o  = r_we;
        wbmadr_o = w_beat_adr;
        wbmdat_o = w_wdat;
        wbmsel_o = w_sel;
        if (wbmack_i) begin
          w_beat_ack = 1'b1;
          if (w_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: these are a handful of flops, not a memory array, so they all
      // take reset. The outputs then read 0 and nothing stale is left over.
      r_beat     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_size     <= '0;
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_rdata    <= '0;
      r_rwe      <= 1'b0;
      r_dat      <= '0;
      r_misalign <= 1'b0;
    end else begin
      // Pulses last one cycle unless set again below.
      r_rwe      <= 1'b0;
      r_misalign <= 1'b0;

      if (w_nomem_hit) begin
        r_rwe <= 1'b1;
        r_dat <= addr_i;
      end

      if (w_mis_hit) begin
        r_misalign <= 1'b1;
      end

      if (w_accept) begin
        r_addr   <= addr_i;
        r_data   <= dat_i;
        r_size   <= size_i;
        r_we     <= we_i;
        r_signed <= signed_i;
        r_beat   <= '0;
        r_rdata  <= '0;
      end

      if (w_beat_ack) begin
        r_beat <= r_beat + 4'd1;
        if (!r_we) begin
          r_rdata <= w_asm;
        end
        if (w_done) begin
          r_beat <= '0;
          if (!r_we) begin
            r_rwe <= 1'b1;
            r_dat <= w_ext;
          end
        end
      end
    end
  end

  assign rwe_o      = r_rwe;
  assign dat_o      = r_dat;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_lsu_multibeat.sv
// -----------------------------------------------------------------------------
// tb_lsu_multibeat
//
// Bench for lsu_multibeat with XLEN=64, DW=16. A byte-addressed memory array
// acts as the Wishbone slave. Expected bus beats come from the address/lane
// rules. Expected load results are read little-endian straight from the
// memory and then extended. Stores are checked by reading the memory back.
// -----------------------------------------------------------------------------
module tb_lsu_multibeat;

  localparam int XLEN = 64;
  localparam int DW   = 16;
  localparam int SW   = DW / 8;

  logic            clk_i;
  logic            reset_i;
  logic            req_i;
  logic            nomem_i;
  logic            we_i;
  logic [1:0]      size_i;
  logic            signed_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] dat_i;
  logic            busy_o;
  logic            rwe_o;
  logic [XLEN-1:0] dat_o;
  logic            misalign_o;
  logic [XLEN-1:0] wbmadr_o;
  logic [DW-1:0]   wbmdat_o;
  logic [DW-1:0]   wbmdat_i;
  logic [SW-1:0]   wbmsel_o;
  logic            wbmwe_o;
  logic            wbmstb_o;
  logic            wbmcyc_o;
  logic            wbmack_i;

  logic [7:0] mem [0:65535];

  int n_cmp;
  int n_err;

  lsu_multibeat #(.XLEN(XLEN), .DW(DW)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .nomem_i    (nomem_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .signed_i   (signed_i),
    .addr_i     (addr_i),
    .dat_i      (dat_i),
    .busy_o     (busy_o),
    .rwe_o      (rwe_o),
    .dat_o      (dat_o),
    .misalign_o (misalign_o),
    .wbmadr_o   (wbmadr_o),
    .wbmdat_o   (wbmdat_o),
    .wbmdat_i   (wbmdat_i),
    .wbmsel_o   (wbmsel_o),
    .wbmwe_o    (wbmwe_o),
    .wbmstb_o   (wbmstb_o),
    .wbmcyc_o   (wbmcyc_o),
    .wbmack_i   (wbmack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int idx);
    return 8'((v >> (idx * 8)) & 64'hFF);
  endfunction

  // Little-endian read of nb bytes from the memory model, extended to 64 bits.
  function automatic logic [63:0] mem_read(input logic [63:0] a, input int nb,
                                           input logic sgn);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      v = v | (64'(mem[16'(a + 64'(i))]) << (8 * i));
    if (sgn && nb < 8 && (((v >> (8 * nb - 1)) & 64'd1) != 0))
      v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  // One complete memory transaction. Call it at a falling edge. It returns
  // at the falling edge after the final ack, where the writeback is visible.
  // wait_mode < 0 picks 0..2 random wait states per beat.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [63:0] adr, input logic [63:0] dat,
                         input int wait_mode, output int stb_cycles,
                         output logic [63:0] got_dat);
    int          nb, nbeats, k, waits, cyc, off;
    logic [63:0] exp_d, exp_adr, base;
    logic [DW-1:0] exp_wd;
    logic [SW-1:0] exp_sel;
    nb      = 1 << sz;
    nbeats  = (nb > SW) ? nb / SW : 1;
    off     = int'(adr[3:0]) % SW;
    exp_d   = mem_read(adr, nb, sgn);
    req_i    = 1'b1;
    nomem_i  = 1'b0;
    we_i     = we;
    size_i   = sz;
    signed_i = sgn;
    addr_i   = adr;
    dat_i    = dat;
    @(negedge clk_i);
    k          = 0;
    cyc        = 0;
    stb_cycles = 0;
    waits      = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
    while (k < nbeats && cyc < 100) begin
      exp_adr = adr + 64'(k * SW);
      for (int l = 0; l < SW; l++) begin
        exp_sel[l]       = (nb > SW) || (l >= off && l < off + nb);
        exp_wd[l*8 +: 8] = (nb > SW) ? byte_of(dat, k * SW + l) : byte_of(dat, l % nb);
      end
      n_cmp++;
      if ({busy_o, wbmcyc_o, wbmstb_o, rwe_o} !== 4'b1110) begin
        n_err++;
        $display("FAIL beat_ctrl: busy/cyc/stb/rwe=%b required 1110 (beat %0d)",
                 {busy_o, wbmcyc_o, wbmstb_o, rwe_o}, k);
      end
      n_cmp++;
      if (wbmadr_o !== exp_adr) begin
        n_err++;
        $display("FAIL beat_adr: got %h required %h (beat %0d)", wbmadr_o, exp_adr, k);
      end
      n_cmp++;
      if (wbmsel_o !== exp_sel || wbmwe_o !== we) begin
        n_err++;
        $display("FAIL beat_sel_we: sel=%b we=%b required sel=%b we=%b",
                 wbmsel_o, wbmwe_o, exp_sel, we);
      end
      if (we) begin
        n_cmp++;
        if (wbmdat_o !== exp_wd) begin
          n_err++;
          $display("FAIL beat_wdat: got %h required %h (beat %0d)", wbmdat_o, exp_wd, k);
        end
      end
      stb_cycles++;
      if (waits > 0) begin
        wbmack_i = 1'b0;
        wbmdat_i = DW'($urandom);
        waits--;
      end else begin
        wbmack_i = 1'b1;
        base     = exp_adr & ~64'(SW - 1);
        wbmdat_i = '0;
        for (int l = 0; l < SW; l++) begin
          wbmdat_i = wbmdat_i | (DW'(mem[16'(base + 64'(l))]) << (8 * l));
          if (we && wbmsel_o[l])
            mem[16'(base + 64'(l))] = byte_of(64'(wbmdat_o), l);
        end
        k++;
        waits = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      end
      cyc++;
      @(negedge clk_i);
    end
    wbmack_i = 1'b0;
    wbmdat_i = DW'($urandom);
    req_i    = 1'b0;
    n_cmp++;
    if (cyc >= 100) begin
      n_err++;
      $display("FAIL txn_timeout: transfer did not finish within %0d cycles", cyc);
    end
    n_cmp++;
    if ({busy_o, wbmstb_o, wbmcyc_o, rwe_o} !== {3'b000, ~we}) begin
      n_err++;
      $display("FAIL txn_end: busy/stb/cyc/rwe=%b required %b",
               {busy_o, wbmstb_o, wbmcyc_o, rwe_o}, {3'b000, ~we});
    end
    if (!we) begin
      n_cmp++;
      if (dat_o !== exp_d) begin
        n_err++;
        $display("FAIL load_data: got %h required %h (size %0d adr %h)", dat_o, exp_d, sz, adr);
      end
    end else begin
      n_cmp++;
      if (mem_read(adr, nb, 1'b0) !== (nb == 8 ? dat : dat & ((64'd1 << (8 * nb)) - 64'd1))) begin
        n_err++;
        $display("FAIL store_mem: got %h required low %0d bytes of %h",
                 mem_read(adr, nb, 1'b0), nb, dat);
      end
    end
    got_dat = dat_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({busy_o, rwe_o, misalign_o, wbmstb_o, wbmcyc_o, wbmwe_o} !== 6'b0 ||
        dat_o !== '0 || wbmadr_o !== '0 || wbmdat_o !== '0 || wbmsel_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: ctl=%b dat=%h adr=%h wdat=%h sel=%b required all 0",
               {busy_o, rwe_o, misalign_o, wbmstb_o, wbmcyc_o, wbmwe_o},
               dat_o, wbmadr_o, wbmdat_o, wbmsel_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_nomem();
    req_i   = 1'b1;
    nomem_i = 1'b1;
    addr_i  = 64'h1122334455667788;
    @(negedge clk_i);
    req_i   = 1'b0;
    nomem_i = 1'b0;
    n_cmp++;
    if ({rwe_o, busy_o, wbmstb_o} !== 3'b100 || dat_o !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL nomem: rwe/busy/stb=%b dat=%h required 100 / 1122334455667788",
               {rwe_o, busy_o, wbmstb_o}, dat_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (rwe_o !== 1'b0 || dat_o !== 64'h1122334455667788 || wbmstb_o !== 1'b0) begin
      n_err++;
      $display("FAIL nomem_after: rwe=%b stb=%b dat=%h required 0 0 held",
               rwe_o, wbmstb_o, dat_o);
    end
  endtask

  task automatic test_stores();
    int          stb;
    logic [63:0] d;
    run_txn(1'b1, 2'd3, 1'b0, 64'h1000, 64'h8877665544332211, 0, stb, d);
    n_cmp++;
    if (stb !== 4) begin
      n_err++;
      $display("FAIL dword_store_beats: got %0d required 4", stb);
    end
    @(negedge clk_i);
    run_txn(1'b1, 2'd0, 1'b0, 64'h1003, 64'h00000000000000AB, 0, stb, d);
    n_cmp++;
    if (stb !== 1 || mem[16'h1003] !== 8'hAB) begin
      n_err++;
      $display("FAIL byte_store: beats=%0d mem=%h required 1 / ab", stb, mem[16'h1003]);
    end
    @(negedge clk_i);
  endtask

  task automatic test_loads();
    int          stb;
    logic [63:0] d;
    mem[16'h2000] = 8'hFF;
    mem[16'h2001] = 8'h80;
    run_txn(1'b0, 2'd0, 1'b1, 64'h2001, 64'h0, 2, stb, d);
    n_cmp++;
    if (stb !== 3 || d !== 64'hFFFFFFFFFFFFFF80) begin
      n_err++;
      $display("FAIL byte_load_signed: stb=%0d dat=%h required 3 / ffffffffffffff80", stb, d);
    end
    @(negedge clk_i);
    n_cmp++;
    if (rwe_o !== 1'b0 || dat_o !== 64'hFFFFFFFFFFFFFF80) begin
      n_err++;
      $display("FAIL rwe_pulse: rwe=%b dat=%h required 0 / held", rwe_o, dat_o);
    end
    run_txn(1'b0, 2'd0, 1'b0, 64'h2001, 64'h0, 2, stb, d);
    n_cmp++;
    if (d !== 64'h80) begin
      n_err++;
      $display("FAIL byte_load_unsigned: got %h required 80", d);
    end
    mem[16'h3000] = 8'hEF;
    mem[16'h3001] = 8'hBE;
    mem[16'h3002] = 8'hAD;
    mem[16'h3003] = 8'hDE;
    run_txn(1'b0, 2'd2, 1'b1, 64'h3000, 64'h0, 1, stb, d);
    n_cmp++;
    if (d !== 64'hFFFFFFFFDEADBEEF) begin
      n_err++;
      $display("FAIL word_load_signed: got %h required ffffffffdeadbeef", d);
    end
    run_txn(1'b0, 2'd2, 1'b0, 64'h3000, 64'h0, 0, stb, d);
    n_cmp++;
    if (d !== 64'h00000000DEADBEEF) begin
      n_err++;
      $display("FAIL word_load_unsigned: got %h required 00000000deadbeef", d);
    end
    @(negedge clk_i);
  endtask

  task automatic test_misaligned();
    logic [1:0]  szs  [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [63:0] adrs [4] = '{64'h1001, 64'h3002, 64'h1004, 64'h5001};
    for (int t = 0; t < 4; t++) begin
      req_i   = 1'b1;
      nomem_i = 1'b0;
      we_i    = t[0];
      size_i  = szs[t];
      addr_i  = adrs[t];
      @(negedge clk_i);
      req_i = 1'b0;
      n_cmp++;
      if ({misalign_o, wbmstb_o, busy_o, rwe_o} !== 4'b1000) begin
        n_err++;
        $display("FAIL misalign_pulse: mis/stb/busy/rwe=%b required 1000 (adr %h)",
                 {misalign_o, wbmstb_o, busy_o, rwe_o}, adrs[t]);
      end
      @(negedge clk_i);
      n_cmp++;
      if ({misalign_o, wbmstb_o} !== 2'b00) begin
        n_err++;
        $display("FAIL misalign_after: mis/stb=%b required 00", {misalign_o, wbmstb_o});
      end
    end
  endtask

  task automatic test_reset_mid();
    req_i    = 1'b1;
    nomem_i  = 1'b0;
    we_i     = 1'b0;
    size_i   = 2'd3;
    signed_i = 1'b0;
    addr_i   = 64'h4000;
    @(negedge clk_i);
    wbmack_i = 1'b1;
    wbmdat_i = 16'h1234;
    @(negedge clk_i);
    wbmack_i = 1'b0;
    n_cmp++;
    if (wbmstb_o !== 1'b1 || wbmadr_o !== 64'h4002) begin
      n_err++;
      $display("FAIL mid_beat2: stb=%b adr=%h required 1 / 4002", wbmstb_o, wbmadr_o);
    end
    #2 reset_i = 1'b1;
    #1;
    n_cmp++;
    if ({wbmstb_o, wbmcyc_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_drop: stb/cyc/busy=%b required 000", {wbmstb_o, wbmcyc_o, busy_o});
    end
    req_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wbmack_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({rwe_o, busy_o, wbmstb_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid_quiet: rwe/busy/stb=%b required 000", {rwe_o, busy_o, wbmstb_o});
      end
    end
    wbmack_i = 1'b0;
  endtask

  // Random aligned loads and stores, issued back to back with random waits.
  task automatic test_random();
    int          stb;
    logic [63:0] d, a;
    logic [1:0]  sz;
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 16'hFFF0)) & ~((64'd1 << sz) - 64'd1);
      run_txn(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, -1, stb, d);
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_i  = 1'b1;
    req_i    = 1'b0;
    nomem_i  = 1'b0;
    we_i     = 1'b0;
    size_i   = 2'd0;
    signed_i = 1'b0;
    addr_i   = '0;
    dat_i    = '0;
    wbmdat_i = '0;
    wbmack_i = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_nomem();
    test_stores();
    test_loads();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
